flash_cmd_sequencer: RTL and testbench
======================================

Name: flash_cmd_sequencer

Overview:
- Command sequencer between spi_ip_core and the byte-wide flash memory port.
- Decodes the received SPI byte stream (D / DATA_DONE) into flash commands: read, page program, read status, write enable/disable.
- Drives the memory handshake and supplies the next return byte on Q for the SPI core to shift out on MISO.

Parameters:
- ADDR_W, 24, memory address width in bits.
- ADDR_BYTES, 3, number of address bytes after opcode, MSB first; ADDR_BYTES*8 >= ADDR_W, excess upper bits discarded.
- PAGE_W, 8, page offset width; program address wraps within a 2^PAGE_W page.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- SPI_RESET  in  1  asynchronous, active-low reset.
- SPI_S  in  1  chip select, active-low, already synchronised to clk.
- RX_DATA  in  8  received byte (spi_ip_core D).
- RX_VALID  in  1  one-cycle pulse, RX_DATA valid (spi_ip_core DATA_DONE).
- TX_DATA  out  8  next byte to shift out (spi_ip_core Q).
- MEM_ADDR  out  ADDR_W  memory byte address.
- MEM_WDATA  out  8  write data.
- MEM_RE  out  1  read strobe; held until MEM_READY.
- MEM_WE  out  1  write strobe; held until MEM_READY.
- MEM_RDATA  in  8  read data, valid in MEM_READY cycle.
- MEM_READY  in  1  completes the pending MEM_RE/MEM_WE.
- BUSY  out  1  memory access outstanding.
- CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset (SPI_RESET=0, async): state IDLE; TX_DATA=8'hFF; MEM_ADDR=0; MEM_WDATA=0; MEM_RE=MEM_WE=0; BUSY=0; CMD_ERR=0; WEL=0.
- States: IDLE, OPCODE, ADDR, RD_FETCH, RD_STREAM, WR_DATA, WR_WAIT, STATUS, IGNORE.
- IDLE -> OPCODE on SPI_S falling (SPI_S=0 sampled while in IDLE).
- OPCODE, on RX_VALID, latches RX_DATA:
  - 8'h03 -> ADDR (read).
  - 8'h02 -> ADDR (program).
  - 8'h05 -> STATUS; TX_DATA={6'b0,WEL,BUSY} the next cycle.
  - 8'h06 -> WEL=1, then IGNORE.
  - 8'h04 -> WEL=0, then IGNORE.
  - Other -> CMD_ERR pulse, then IGNORE.
- ADDR: shifts in ADDR_BYTES bytes MSB first; after the last byte MEM_ADDR=the assembled address, then branches:
  - Read -> RD_FETCH.
  - Program with WEL=1 -> WR_DATA.
  - Program with WEL=0 -> CMD_ERR pulse, then IGNORE.
- RD_FETCH: MEM_RE=1 and BUSY=1 from the cycle after entry. On MEM_READY: TX_DATA<=MEM_RDATA, MEM_RE=0, MEM_ADDR<=MEM_ADDR+1 (wraps mod 2^ADDR_W), go to RD_STREAM.
- RD_STREAM: each RX_VALID (dummy byte) re-enters RD_FETCH to prefetch the next byte. TX_DATA holds its value until the next MEM_READY.
- WR_DATA: on RX_VALID, MEM_WDATA<=RX_DATA, MEM_WE=1, BUSY=1, go to WR_WAIT.
- WR_WAIT: on MEM_READY, MEM_WE=0, then increment the low PAGE_W bits of MEM_ADDR only (page wrap), and go to WR_DATA.
- Overrun: RX_VALID during RD_FETCH or WR_WAIT drops the byte and pulses CMD_ERR; the state is unchanged.
- STATUS: TX_DATA refreshed every cycle while SPI_S=0.
- IGNORE: consumes all bytes, no memory activity.
- SPI_S rising (SPI_S=1) in any state:
  - No access pending: go to IDLE next cycle; TX_DATA=8'hFF.
  - In RD_FETCH or WR_WAIT: the pending strobe stays asserted until MEM_READY, then go to IDLE.
  - A program command that entered WR_DATA clears WEL on deselect.
- Simultaneous MEM_READY and RX_VALID in WR_WAIT: the write completes, the byte is dropped, and CMD_ERR pulses.
- Simultaneous SPI_S=1 and RX_VALID: deselect wins; the byte is ignored.
- Latency: opcode byte to TX_DATA status = 1 clk. Read address last byte to MEM_RE = 1 clk.
- MEM_RE and MEM_WE are never asserted together. Strobes are level signals with no combinational path from MEM_READY.

Test Plan:
- Reset mid-read (MEM_RE=1): assert SPI_RESET=0 -> all outputs reset immediately, TX_DATA=FF, MEM_RE=0, WEL=0.
- Select; bytes 03 00 01 23; memory returns AA at 000123 and BB at 000124; one dummy byte -> MEM_RE at 000123 then 000124; TX_DATA AA then BB; CMD_ERR never pulses.
- Select 06 deselect; select 02 00 00 FE, data 11 22 33 -> writes 0000FE=11, 0000FF=22, 000000=33 (page wrap); after deselect WEL=0.
- Select 02 00 00 10 55 without a prior 06 -> CMD_ERR pulse after the third address byte; no MEM_WE.
- Select 06 deselect; select 05 -> TX_DATA=02. Select 04 deselect; select 05 -> TX_DATA=00. Select opcode 9F -> CMD_ERR pulse, later bytes ignored.
- Program with MEM_READY delayed 50 clk; second data byte arrives during WR_WAIT -> byte dropped, one CMD_ERR pulse. Deselect while MEM_WE is high -> MEM_WE holds until MEM_READY, then IDLE.

Source files
------------

// File: rtl/flash_cmd_sequencer.sv
// Flash command sequencer: decodes the SPI byte stream into read / program /
// status / write-enable commands and drives the byte-wide memory handshake.
module flash_cmd_sequencer #(
    parameter int ADDR_W     = 24,
    parameter int ADDR_BYTES = 3,
    parameter int PAGE_W     = 8
) (
    input  logic              clk,
    input  logic              SPI_RESET,
    input  logic              SPI_S,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic [7:0]        TX_DATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              MEM_RE,
    output logic              MEM_WE,
    input  logic [7:0]        MEM_RDATA,
    input  logic              MEM_READY,
    output logic              BUSY,
    output logic              CMD_ERR
);
    localparam int SH_W  = ADDR_BYTES * 8;
    localparam int CNT_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] OPCODE    = 4'd1;
    localparam logic [3:0] ADDR      = 4'd2;
    localparam logic [3:0] RD_FETCH  = 4'd3;
    localparam logic [3:0] RD_STREAM = 4'd4;
    localparam logic [3:0] WR_DATA   = 4'd5;
    localparam logic [3:0] WR_WAIT   = 4'd6;
    localparam logic [3:0] STATUS    = 4'd7;
    localparam logic [3:0] IGNORE    = 4'd8;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PROG = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;

    logic [3:0]        state;
    logic              wel;
    logic              is_read;
    logic              wr_entered;
    logic [CNT_W-1:0]  addr_cnt;
    logic [SH_W-1:0]   addr_sh;
    logic [SH_W-1:0]   addr_sh_nxt;
    logic              addr_last;
    logic [PAGE_W-1:0] page_off_nxt;
    logic [7:0]        status_byte;

    assign BUSY         = MEM_RE | MEM_WE;
    assign addr_sh_nxt  = (addr_sh << 8) | SH_W'(RX_DATA);
    assign addr_last    = (addr_cnt == CNT_W'(ADDR_BYTES - 1));
    assign page_off_nxt = MEM_ADDR[PAGE_W-1:0] + PAGE_W'(1);
    assign status_byte  = {6'b0, wel, BUSY};

    always_ff @(posedge clk or negedge SPI_RESET) begin
        if (!SPI_RESET) begin
            state      <= IDLE;
            TX_DATA    <= 8'hFF;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= 8'h00;
            MEM_RE     <= 1'b0;
            MEM_WE     <= 1'b0;
            CMD_ERR    <= 1'b0;
            wel        <= 1'b0;
            is_read    <= 1'b0;
            wr_entered <= 1'b0;
            addr_cnt   <= '0;
            addr_sh    <= '0;
        end else begin
            CMD_ERR <= 1'b0;
            case (state)
                // Pending accesses must finish even after deselect; bytes
                // arriving meanwhile are overruns unless deselect is present.
                RD_FETCH: begin
                    if (MEM_READY) begin
                        MEM_RE   <= 1'b0;
                        MEM_ADDR <= MEM_ADDR + ADDR_W'(1);
                        if (SPI_S) begin
                            state   <= IDLE;
                            TX_DATA <= 8'hFF;
                        end else begin
                            state   <= RD_STREAM;
                            TX_DATA <= MEM_RDATA;
                        end
                    end
                    if (RX_VALID && !SPI_S) begin
                        CMD_ERR <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (MEM_READY) begin
                        MEM_WE   <= 1'b0;
                        MEM_ADDR <= {MEM_ADDR[ADDR_W-1:PAGE_W], page_off_nxt};
                        if (SPI_S) begin
                            state      <= IDLE;
                            TX_DATA    <= 8'hFF;
                            wel        <= 1'b0;
                            wr_entered <= 1'b0;
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                    if (RX_VALID && !SPI_S) begin
                        CMD_ERR <= 1'b1;
                    end
                end
                default: begin
                    if (SPI_S) begin
                        state   <= IDLE;
                        TX_DATA <= 8'hFF;
                        if (wr_entered) begin
                            wel <= 1'b0;
                        end
                        wr_entered <= 1'b0;
                    end else begin
                        case (state)
                            IDLE: begin
                                state    <= OPCODE;
                                addr_cnt <= '0;
                            end
                            OPCODE: begin
                                if (RX_VALID) begin
                                    case (RX_DATA)
                                        OP_READ: begin
                                            is_read <= 1'b1;
                                            state   <= ADDR;
                                        end
                                        OP_PROG: begin
                                            is_read <= 1'b0;
                                            state   <= ADDR;
                                        end
                                        OP_RDSR: begin
                                            TX_DATA <= status_byte;
                                            state   <= STATUS;
                                        end
                                        OP_WREN: begin
                                            wel   <= 1'b1;
                                            state <= IGNORE;
                                        end
                                        OP_WRDI: begin
                                            wel   <= 1'b0;
                                            state <= IGNORE;
                                        end
                                        default: begin
                                            CMD_ERR <= 1'b1;
                                            state   <= IGNORE;
                                        end
                                    endcase
                                end
                            end
                            ADDR: begin
                                if (RX_VALID) begin
                                    addr_sh  <= addr_sh_nxt;
                                    addr_cnt <= addr_cnt + CNT_W'(1);
                                    if (addr_last) begin
                                        MEM_ADDR <= addr_sh_nxt[ADDR_W-1:0];
                                        if (is_read) begin
                                            MEM_RE <= 1'b1;
                                            state  <= RD_FETCH;
                                        end else if (wel) begin
                                            wr_entered <= 1'b1;
                                            state      <= WR_DATA;
                                        end else begin
                                            CMD_ERR <= 1'b1;
                                            state   <= IGNORE;
                                        end
                                    end
                                end
                            end
                            RD_STREAM: begin
                                // Each dummy byte prefetches the next location.
                                if (RX_VALID) begin
                                    MEM_RE <= 1'b1;
                                    state  <= RD_FETCH;
                                end
                            end
                            WR_DATA: begin
                                if (RX_VALID) begin
                                    MEM_WDATA <= RX_DATA;
                                    MEM_WE    <= 1'b1;
                                    state     <= WR_WAIT;
                                end
                            end
                            STATUS: begin
                                TX_DATA <= status_byte;
                            end
                            IGNORE: begin
                                state <= IGNORE;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Randomized bench for flash_cmd_sequencer: a transaction-level reference model
// predicts memory accesses, TX bytes, error pulses and the write-enable latch.
module tb_flash_cmd_sequencer;
    localparam int AB  = 3;
    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        SPI_RESET;
    logic        SPI_S;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic [7:0]  TX_DATA;
    logic [23:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_RE;
    logic        MEM_WE;
    logic [7:0]  MEM_RDATA;
    logic        MEM_READY;
    logic        BUSY;
    logic        CMD_ERR;

    always #5 clk = ~clk;

    flash_cmd_sequencer #(.ADDR_W(24), .ADDR_BYTES(AB), .PAGE_W(8)) dut (
        .clk(clk), .SPI_RESET(SPI_RESET), .SPI_S(SPI_S),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .TX_DATA(TX_DATA),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RE(MEM_RE),
        .MEM_WE(MEM_WE), .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY),
        .BUSY(BUSY), .CMD_ERR(CMD_ERR)
    );

    int n_chk = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int rdy_delay = 0;
    int wait_cnt = 0;

    logic [7:0]  env_mem [logic [23:0]];
    logic [7:0]  ref_mem [logic [23:0]];
    logic [23:0] rd_log[$];
    logic [31:0] wr_log[$];
    logic [7:0]  txn_q[$];
    logic [23:0] exp_rd[$];
    logic [31:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          exp_err;
    logic        exp_wel = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dflt(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] env_rd(input logic [23:0] a);
        return env_mem.exists(a) ? env_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Memory device: completes each strobe after rdy_delay cycles with a one-cycle READY.
    initial begin
        MEM_READY = 1'b0;
        MEM_RDATA = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (MEM_READY) begin
                MEM_READY = 1'b0;
            end else if (MEM_RE || MEM_WE) begin
                if (wait_cnt >= rdy_delay) begin
                    wait_cnt  = 0;
                    MEM_READY = 1'b1;
                    if (MEM_RE) begin
                        MEM_RDATA = env_rd(MEM_ADDR);
                        rd_log.push_back(MEM_ADDR);
                    end else begin
                        env_mem[MEM_ADDR] = MEM_WDATA;
                        wr_log.push_back({MEM_ADDR, MEM_WDATA});
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (CMD_ERR) err_cnt++;
        if (MEM_RE && MEM_WE) both_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference model: what one complete select..deselect transaction must do.
    task automatic model_txn();
        int n;
        int nd;
        logic [7:0]  op;
        logic [23:0] a;
        logic [23:0] ra;
        logic [23:0] wa;
        n = txn_q.size();
        exp_rd.delete();
        exp_wr.delete();
        exp_tx.delete();
        exp_err = 0;
        for (int i = 0; i < n; i++) exp_tx.push_back(8'hFF);
        if (n == 0) return;
        op = txn_q[0];
        case (op)
            8'h03, 8'h02: if (n >= 1 + AB) begin
                a = 24'h0;
                for (int k = 1; k <= AB; k++) a = a * 256 + 24'(txn_q[k]);
                nd = n - 1 - AB;
                if (op == 8'h03) begin
                    for (int k = 0; k <= nd; k++) begin
                        ra = a + 24'(k);
                        exp_rd.push_back(ra);
                        exp_tx[AB + k] = ref_rd(ra);
                    end
                end else if (exp_wel) begin
                    for (int k = 0; k < nd; k++) begin
                        wa = (a & 24'hFFFF00) | ((a + 24'(k)) & 24'h0000FF);
                        exp_wr.push_back({wa, txn_q[1 + AB + k]});
                        ref_mem[wa] = txn_q[1 + AB + k];
                    end
                    exp_wel = 1'b0;
                end else begin
                    exp_err = 1;
                end
            end
            8'h05: for (int i = 0; i < n; i++) exp_tx[i] = {6'b0, exp_wel, 1'b0};
            8'h06: exp_wel = 1'b1;
            8'h04: exp_wel = 1'b0;
            default: exp_err = 1;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge clk);
        RX_VALID = 1'b0;
    endtask

    task automatic check_logs();
        chk("rd_count", rd_log.size(), exp_rd.size());
        for (int k = 0; k < rd_log.size() && k < exp_rd.size(); k++)
            chk("rd_addr", rd_log[k], exp_rd[k]);
        chk("wr_count", wr_log.size(), exp_wr.size());
        for (int k = 0; k < wr_log.size() && k < exp_wr.size(); k++)
            chk("wr_addr_data", wr_log[k], exp_wr[k]);
        rd_log.delete();
        wr_log.delete();
    endtask

    task automatic run_txn();
        int   n;
        int   e0;
        int   to;
        logic wel0;
        n    = txn_q.size();
        wel0 = exp_wel;
        model_txn();
        e0 = err_cnt;
        @(negedge clk);
        SPI_S = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            send_byte(txn_q[i]);
            if (txn_q[0] == 8'h05) chk("status_latency", TX_DATA, exp_tx[i]);
            if (txn_q[0] == 8'h03 && i == AB) chk("re_latency", MEM_RE, 1);
            if (txn_q[0] == 8'h02 && wel0 && i > AB) chk("we_strobe", MEM_WE, 1);
            repeat (GAP) @(negedge clk);
            chk("tx_byte", TX_DATA, exp_tx[i]);
        end
        SPI_S = 1'b1;
        to = 0;
        while (BUSY && to < 300) begin
            @(negedge clk);
            to++;
        end
        chk("busy_after_deselect", BUSY, 0);
        repeat (2) @(negedge clk);
        chk("tx_idle", TX_DATA, 8'hFF);
        chk("cmd_err_pulses", err_cnt - e0, exp_err);
        check_logs();
        chk("re_we_overlap", both_cnt, 0);
    endtask

    task automatic do_reset();
        SPI_RESET = 1'b0;
        repeat (3) @(negedge clk);
        SPI_RESET = 1'b1;
        exp_wel = 1'b0;
    endtask

    initial begin
        int to;
        int e0;
        int r;
        int n;
        logic [7:0] op;
        SPI_S    = 1'b1;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        SPI_RESET = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", TX_DATA, 8'hFF);
        chk("rst_addr", MEM_ADDR, 0);
        chk("rst_wdata", MEM_WDATA, 0);
        chk("rst_re_we", {MEM_RE, MEM_WE}, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_err", CMD_ERR, 0);
        SPI_RESET = 1'b1;
        repeat (2) @(negedge clk);

        // Read with one dummy byte: AA at 000123, BB at 000124.
        rdy_delay = 1;
        env_mem[24'h000123] = 8'hAA; ref_mem[24'h000123] = 8'hAA;
        env_mem[24'h000124] = 8'hBB; ref_mem[24'h000124] = 8'hBB;
        txn_q = {8'h03, 8'h00, 8'h01, 8'h23, 8'h00};
        run_txn();

        // Program across the page boundary.
        txn_q = {8'h06}; run_txn();
        txn_q = {8'h02, 8'h00, 8'h00, 8'hFE, 8'h11, 8'h22, 8'h33}; run_txn();
        txn_q = {8'h05}; run_txn();
        txn_q = {8'h03, 8'h00, 8'h00, 8'hFF, 8'h00}; run_txn();

        // Program without write enable, status after WREN/WRDI, unknown opcode.
        txn_q = {8'h02, 8'h00, 8'h00, 8'h10, 8'h55}; run_txn();
        txn_q = {8'h06}; run_txn();
        txn_q = {8'h05, 8'h00}; run_txn();
        txn_q = {8'h04}; run_txn();
        txn_q = {8'h05, 8'h00}; run_txn();
        txn_q = {8'h9F, 8'h03, 8'h00}; run_txn();

        // Slow memory: overrun during WR_WAIT, then deselect with MEM_WE high.
        txn_q = {8'h06}; run_txn();
        rdy_delay = 50;
        @(negedge clk); SPI_S = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        repeat (2) @(negedge clk);
        send_byte(8'h77);
        chk("slow_we_high", MEM_WE, 1);
        repeat (5) @(negedge clk);
        e0 = err_cnt;
        send_byte(8'h88);
        repeat (2) @(negedge clk);
        chk("overrun_err", err_cnt - e0, 1);
        SPI_S = 1'b1;
        repeat (5) @(negedge clk);
        chk("we_hold_after_deselect", MEM_WE, 1);
        to = 0;
        while (MEM_WE && to < 300) begin @(negedge clk); to++; end
        chk("we_released", MEM_WE, 0);
        repeat (2) @(negedge clk);
        chk("slow_tx_idle", TX_DATA, 8'hFF);
        exp_rd.delete(); exp_wr.delete();
        exp_wr.push_back({24'h000040, 8'h77});
        ref_mem[24'h000040] = 8'h77;
        exp_wel = 1'b0;
        check_logs();
        rdy_delay = 1;
        txn_q = {8'h05}; run_txn();

        // Async reset in the middle of a slow read.
        txn_q = {8'h06}; run_txn();
        rdy_delay = 50;
        @(negedge clk); SPI_S = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        repeat (3) @(negedge clk);
        chk("read_pending", MEM_RE, 1);
        #2 SPI_RESET = 1'b0;
        #1;
        chk("arst_re", MEM_RE, 0);
        chk("arst_tx", TX_DATA, 8'hFF);
        chk("arst_busy", BUSY, 0);
        chk("arst_addr", MEM_ADDR, 0);
        @(negedge clk);
        SPI_S = 1'b1;
        @(negedge clk);
        SPI_RESET = 1'b1;
        exp_wel = 1'b0;
        rd_log.delete(); wr_log.delete();
        rdy_delay = 1;
        txn_q = {8'h05}; run_txn();

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            rdy_delay = $urandom_range(0, 4);
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: op = 8'h03;
                3, 4, 5: op = 8'h02;
                6:       op = 8'h05;
                7:       op = 8'h06;
                8:       op = 8'h04;
                default: op = 8'($urandom_range(0, 255));
            endcase
            if (op == 8'h02 && $urandom_range(0, 2) != 0) begin
                txn_q = {8'h06};
                run_txn();
            end
            n = $urandom_range(1, AB + 5);
            txn_q.delete();
            txn_q.push_back(op);
            r = $urandom_range(0, 3);
            for (int i = 1; i < n; i++) begin
                if (i < AB && r == 0) txn_q.push_back(8'hFF);
                else if (i == AB && $urandom_range(0, 1) == 1) txn_q.push_back(8'hFC + 8'($urandom_range(0, 3)));
                else txn_q.push_back(8'($urandom_range(0, 255)));
            end
            run_txn();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
